reg_file_p: RTL and testbench

Parametrised successor to the core's register file. It has NREGS entries of XLEN bits, two synchronous read ports, one write port, write-first bypass and an optional hardwired zero register. After reset, an internal sequencer clears the array one entry per cycle and holds ready low until the clear completes. It sits between decode (read addresses) and writeback (write port) in the RV32 datapath.

---
 rtl/reg_file_p.sv | 129 ++++++++++++
 tb/tb_reg_file_p.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_p.sv
// reg_file_p: parametrised register file with two synchronous read ports and
// one write port. Writes take priority over reads to the same address
// (write-first bypass). Entry 0 can be hardwired to zero.
// After reset the array is cleared one entry per cycle, and ready stays low
// until every entry has been cleared.
//
// Ports
//   clk     : system clock, rising edge
//   rst_n   : synchronous reset, active-low
//   we      : write enable
//   waddr   : write address (rd)
//   wdata   : write data
//   re      : read enable, samples raddr1/raddr2
//   raddr1  : read address, port 1 (rs1)
//   raddr2  : read address, port 2 (rs2)
//   rdata1  : registered read data, port 1
//   rdata2  : registered read data, port 2
//   rvalid  : rdata1/rdata2 updated by a read accepted on the previous cycle
//   ready   : array cleared; reads and writes are accepted
//
// state    | meaning
// ST_CLEAR | zeroing entry[cnt_q] each cycle; we/re ignored, ready low
// ST_RUN   | normal operation, ready high
module reg_file_p #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            rvalid,
  output logic            ready
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic          ZR   = (ZERO_REG != 0);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] rdata1_q, rdata1_d;
  logic [XLEN-1:0] rdata2_q, rdata2_d;
  logic            rvalid_q;
  logic            ready_q;
  logic            wr_en;

  // Writes to entry 0 are dropped when it is the hardwired zero register.
  assign wr_en = we && (state_q == ST_RUN) && !(ZR && (waddr == '0));

  // Zero-register check sits ahead of the bypass so x0 reads 0 even when
  // a same-cycle write targets it.
  always_comb begin
    rdata1_d = rdata1_q;
    if (re && (state_q == ST_RUN)) begin
      if (ZR && (raddr1 == '0))
        rdata1_d = '0;
      else if (we && (raddr1 == waddr))
        rdata1_d = wdata;
      else
        rdata1_d = regs_q[raddr1];
    end
  end

  always_comb begin
    rdata2_d = rdata2_q;
    if (re && (state_q == ST_RUN)) begin
      if (ZR && (raddr2 == '0))
        rdata2_d = '0;
      else if (we && (raddr2 == waddr))
        rdata2_d = wdata;
      else
        rdata2_d = regs_q[raddr2];
    end
  end

  // The array itself is deliberately left untouched by reset; the clear
  // sequence that follows zeroes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          regs_q[cnt_q] <= '0;
          cnt_q         <= cnt_q + AW'(1);
          rvalid_q      <= 1'b0;
          if (cnt_q == LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wr_en)
            regs_q[waddr] <= wdata;
          rdata1_q <= rdata1_d;
          rdata2_q <= rdata2_d;
          rvalid_q <= re;
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdata1 = rdata1_q;
  assign rdata2 = rdata2_q;
  assign rvalid = rvalid_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_reg_file_p.sv
module tb_reg_file_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // dut_a (ZERO_REG=1) and dut_b (ZERO_REG=0) share stimulus.
  logic        we, re;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_rv, a_rdy, b_rv, b_rdy;

  // dut_c: XLEN=64, NREGS=16
  logic        c_we, c_re;
  logic [3:0]  c_waddr, c_raddr1, c_raddr2;
  logic [63:0] c_wdata, c_rd1, c_rd2;
  logic        c_rv, c_rdy;

  reg_file_p #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(a_rd1), .rdata2(a_rd2), .rvalid(a_rv), .ready(a_rdy));

  reg_file_p #(.XLEN(32), .NREGS(32), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(b_rd1), .rdata2(b_rd2), .rvalid(b_rv), .ready(b_rdy));

  reg_file_p #(.XLEN(64), .NREGS(16), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .re(c_re), .raddr1(c_raddr1), .raddr2(c_raddr2),
    .rdata1(c_rd1), .rdata2(c_rd2), .rvalid(c_rv), .ready(c_rdy));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises on each 32-entry and 16-entry instance,
  // while checking that outputs stay quiet and we/re are ignored.
  task automatic run_clear(input string tag);
    int  cyc_a, cyc_c;
    logic quiet_ok;
    cyc_a = 0; cyc_c = 0; quiet_ok = 1'b1;
    we = 1'b1; waddr = 5'd5; wdata = 32'hBAD0BAD0;
    re = 1'b1; raddr1 = 5'd5; raddr2 = 5'd1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cyc_c == 0 && c_rdy) cyc_c = i;
      if (a_rdy) begin
        cyc_a = i;
        break;
      end
      if (a_rd1 != 0 || a_rd2 != 0 || a_rv || b_rd1 != 0 || b_rd2 != 0 || b_rv)
        quiet_ok = 1'b0;
    end
    we = 1'b0; re = 1'b0;
    chk({tag, "_ready_cycles32"}, 64'(cyc_a), 64'd32);
    chk({tag, "_ready_b"}, 64'(b_rdy), 64'd1);
    chk({tag, "_ready_cycles16"}, 64'(cyc_c), 64'd16);
    chk({tag, "_quiet_during_clear"}, 64'(quiet_ok), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    we = 0; re = 0; waddr = 0; raddr1 = 0; raddr2 = 0; wdata = 0;
    c_we = 0; c_re = 0; c_waddr = 0; c_raddr1 = 0; c_raddr2 = 0; c_wdata = 0;

    // 1: reset, clear, every entry reads zero
    tick(); tick();
    chk("rst_ready", 64'(a_rdy), 64'd0);
    chk("rst_rvalid", 64'(a_rv), 64'd0);
    chk("rst_rdata1", 64'(a_rd1), 64'd0);
    chk("rst_rdata2", 64'(a_rd2), 64'd0);
    rst_n = 1'b1;
    run_clear("clr1");
    for (int a = 0; a < 32; a++) begin
      re = 1'b1; raddr1 = 5'(a); raddr2 = 5'(31 - a);
      tick();
      chk($sformatf("zero_a_p1_x%0d", a), 64'(a_rd1), 64'd0);
      chk($sformatf("zero_a_p2_x%0d", 31 - a), 64'(a_rd2), 64'd0);
      chk($sformatf("zero_b_p1_x%0d", a), 64'(b_rd1), 64'd0);
      chk($sformatf("zero_rvalid_x%0d", a), 64'(a_rv), 64'd1);
    end
    re = 1'b0;

    // 2: write then read same address on both ports
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; re = 1'b1; raddr1 = 5'd5; raddr2 = 5'd5;
    tick();
    chk("x5_p1", 64'(a_rd1), 64'hDEADBEEF);
    chk("x5_p2", 64'(a_rd2), 64'hDEADBEEF);
    chk("x5_rvalid", 64'(a_rv), 64'd1);
    re = 1'b0;
    tick();
    chk("hold_rvalid0", 64'(a_rv), 64'd0);
    chk("hold_p1", 64'(a_rd1), 64'hDEADBEEF);

    // 3: bypass on port 1, plain read on port 2
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    re = 1'b1; raddr1 = 5'd7; raddr2 = 5'd6;
    tick();
    chk("byp_p1", 64'(a_rd1), 64'h12345678);
    chk("byp_p2", 64'(a_rd2), 64'd0);
    // write x5 while reading x7: read sees stored x7
    we = 1'b1; waddr = 5'd5; wdata = 32'h11111111;
    re = 1'b1; raddr1 = 5'd7; raddr2 = 5'd5;
    tick();
    chk("x7_stored", 64'(a_rd1), 64'h12345678);
    chk("x5_bypass", 64'(a_rd2), 64'h11111111);
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd6;
    tick();
    chk("x5_new", 64'(a_rd1), 64'h11111111);
    chk("x6_other", 64'(a_rd2), 64'd0);

    // 4: zero register vs ordinary entry 0
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
    tick();
    chk("x0_byp_a", 64'(a_rd1), 64'd0);
    chk("x0_byp_b", 64'(b_rd1), 64'hFFFFFFFF);
    we = 1'b0;
    tick();
    chk("x0_later_a", 64'(a_rd1), 64'd0);
    chk("x0_later_a_p2", 64'(a_rd2), 64'd0);
    chk("x0_later_b", 64'(b_rd1), 64'hFFFFFFFF);

    // 5: reset mid-operation and again mid-clear
    we = 1'b1; waddr = 5'd3; wdata = 32'h000000A5; re = 1'b0;
    tick();
    we = 1'b0; re = 1'b1; raddr1 = 5'd3; raddr2 = 5'd3;
    tick();
    chk("x3_a5", 64'(a_rd1), 64'hA5);
    chk("x3_rvalid", 64'(a_rv), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_rvalid", 64'(a_rv), 64'd0);
    chk("midrst_rdata1", 64'(a_rd1), 64'd0);
    chk("midrst_ready", 64'(a_rdy), 64'd0);
    rst_n = 1'b1; re = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("clr_partial_ready", 64'(a_rdy), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_clear("clr2");
    re = 1'b1; raddr1 = 5'd3; raddr2 = 5'd7;
    tick();
    chk("x3_cleared", 64'(a_rd1), 64'd0);
    chk("x7_cleared", 64'(a_rd2), 64'd0);
    re = 1'b0;

    // 6: 64-bit, 16-entry instance
    c_we = 1'b1; c_waddr = 4'd15; c_wdata = 64'h0123456789ABCDEF;
    tick();
    c_we = 1'b0; c_re = 1'b1; c_raddr1 = 4'd15; c_raddr2 = 4'd0;
    tick();
    chk("c_x15", c_rd1, 64'h0123456789ABCDEF);
    chk("c_x0", c_rd2, 64'd0);
    chk("c_rvalid", 64'(c_rv), 64'd1);
    c_re = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("c_hold_data%0d", i), c_rd1, 64'h0123456789ABCDEF);
      chk($sformatf("c_hold_rvalid%0d", i), 64'(c_rv), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
